// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported synchronous data memory between the
// pipeline MEM stage (CPU port) and the loader/debug port (DBG port).
// Each transaction takes an ACCESS cycle, in which the registered address,
// data and write enable sit on the memory pins, followed by a RESP cycle, in
// which the owner sees a one-cycle ack and the memory's registered read data.
//
// Handshake: a requester raises req and holds it, along with we/addr/wdata,
// until it sees ack. Ack is a single-cycle pulse, and read data is valid
// only while ack is high. A req that is still high on the closing edge of
// the ack cycle is taken as a new back-to-back transaction.
//
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration on
// conflicts. The default build gives the CPU fixed priority.
module dmem_arbiter #(
  parameter int ASIZE = 8,
  parameter int DSIZE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cpu_req,
  input  logic             i_cpu_we,
  input  logic [ASIZE-1:0] i_cpu_addr,
  input  logic [DSIZE-1:0] i_cpu_wdata,
  output logic             o_cpu_ack,
  output logic [DSIZE-1:0] o_cpu_rdata,
  output logic             o_cpu_stall,
  input  logic             i_dbg_req,
  input  logic             i_dbg_we,
  input  logic [ASIZE-1:0] i_dbg_addr,
  input  logic [DSIZE-1:0] i_dbg_wdata,
  output logic             o_dbg_ack,
  output logic [DSIZE-1:0] o_dbg_rdata,
  output logic [ASIZE-1:0] o_mem_addr,
  output logic [DSIZE-1:0] o_mem_wdata,
  output logic             o_mem_we,
  input  logic [DSIZE-1:0] i_mem_rdata,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  state_t r_state;
  state_t w_next_state;
  logic   r_owner;
  logic   w_any_req;
  logic   w_grant_dbg;
  logic   w_load;

  assign w_any_req = i_cpu_req | i_dbg_req;

`ifdef DMEM_ARB_RR_EN
  // Round-robin: the pointer remembers the last granted port, and on a
  // conflict the other port wins. It resets to DBG so the CPU wins first.
  logic r_rr_ptr;

  // Record the port granted by each new transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_rr_ptr <= OWN_DBG;
    else if (w_load) r_rr_ptr <= w_grant_dbg;
  end

  assign w_grant_dbg = i_dbg_req & (~i_cpu_req | (r_rr_ptr == OWN_CPU));
`else
  // Fixed priority: DBG wins only when the CPU is not requesting.
  assign w_grant_dbg = i_dbg_req & ~i_cpu_req;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic, grant strobe and the per-port responses.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    o_cpu_ack    = 1'b0;
    o_dbg_ack    = 1'b0;
    o_cpu_rdata  = '0;
    o_dbg_rdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_next_state = S_ACCESS;
          w_load       = 1'b1;
        end
      end
      S_ACCESS: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        if (r_owner == OWN_CPU) begin
          o_cpu_ack   = 1'b1;
          o_cpu_rdata = i_mem_rdata;
        end else begin
          o_dbg_ack   = 1'b1;
          o_dbg_rdata = i_mem_rdata;
        end
        if (w_any_req) begin
          w_next_state = S_ACCESS;
          w_load       = 1'b1;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Memory pin registers and owner. A grant loads the winner's access, and
  // the write enable drops on every other edge so it is high only in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_CPU;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_we    <= 1'b0;
    end else if (w_load) begin
      r_owner     <= w_grant_dbg;
      o_mem_addr  <= w_grant_dbg ? i_dbg_addr  : i_cpu_addr;
      o_mem_wdata <= w_grant_dbg ? i_dbg_wdata : i_cpu_wdata;
      o_mem_we    <= w_grant_dbg ? i_dbg_we    : i_cpu_we;
    end else begin
      o_mem_we    <= 1'b0;
    end
  end

  assign o_cpu_stall = i_cpu_req & ~o_cpu_ack;
  assign o_dbg_state = r_state;

endmodule
